touch_panel_ctrl: RTL and testbench
===================================

// Module: touch_panel_ctrl
// PURPOSE
// - Parametrised touch-panel front end: converts raw ADC coordinates + pen IRQ into UI events for the synth editor.
// - Decodes a COLS x ROWS character grid (cell select), and a slider bar with minus/plus buttons editing the selected cell.
// - Sits between the touch ADC serialiser and the parameter/display RAM; emits one value write per edit action.
// PARAMETERS
// - COORD_W 8 : coordinate width.  VAL_W 8 : parameter value width.  VAL_MAX 127 : max slider value.
// - GRID_X0 7 / GRID_Y0 7 : grid origin.  CELL_W 19 / CELL_H 8 : cell size.  COLS 12 / ROWS 11 : grid size.
// - SL_X0 40 / SL_X1 220 / SL_Y0 155 / SL_Y1 168 : slider bar box (inclusive).  BTN_W 20 : minus/plus width either side.
// - SAMPLE_N 3 : coord_valid pulses to skip after pen-down before latching hit.  REL_CYC 8 : pen-up debounce cycles.
// - RPT_DLY 24'd5_000_000 / RPT_PER 24'd1_000_000 : auto-repeat delay/period in sys_clk cycles.
// PORTS
// - sys_clk      in  1        system clock
// - iRST_n       in  1        asynchronous, active-low reset
// - x, y         in  COORD_W  current ADC coordinate, stable while coord_valid high
// - coord_valid  in  1        one-cycle pulse per new coordinate pair
// - penirq_n     in  1        pen IRQ, active-low, asynchronous (2-flop synchronised internally)
// - rd_data      in  VAL_W    value of cell rd_idx, combinational, valid same cycle
// - rd_idx       out 8        row*COLS+col of selected cell
// - cell_col/cell_row out 4   selected cell; cell_sel out 1 one-cycle pulse on new selection
// - wr_val       out VAL_W    edited value; wr_en out 1 one-cycle write strobe (index = rd_idx)
// - hit_x, hit_y out COORD_W  latched hit coordinate (status/debug)
// - busy         out 1        high in any state except IDLE
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, cur_val 0, sample counter 0; reset mid-operation aborts with no strobe.
// - FSM: IDLE -> SETTLE on synced pen low. SETTLE counts coord_valid; on pulse SAMPLE_N+1 latch x,y -> DECODE.
// - Pen release in SETTLE (synced high) -> IDLE, no event. Exactly SAMPLE_N pulses then release: no event.
// - DECODE (1 cycle): register region class: GRID, SLIDE, MINUS, PLUS, NONE; col=(hit_x-GRID_X0)/CELL_W, row=(hit_y-GRID_Y0)/CELL_H.
// - GRID valid only if hit_x>=GRID_X0, hit_y>=GRID_Y0, col<COLS, row<ROWS; else NONE. Boxes inclusive at both edges.
// - MINUS: x in [SL_X0-BTN_W, SL_X0-1]; PLUS: x in [SL_X1+1, SL_X1+BTN_W]; both with y in slider box.
// - ACT (1 cycle): GRID -> update col/row/rd_idx, pulse cell_sel; cur_val <= rd_data one cycle later (LOAD substate).
// - SLIDE -> v=((hit_x-SL_X0)*(VAL_MAX+1))/(SL_X1-SL_X0+1), clamped to VAL_MAX; cur_val<=v, wr_en pulse.
// - MINUS -> if cur_val!=0 decrement + wr_en, else no strobe. PLUS -> if cur_val<VAL_MAX increment + wr_en, else no strobe.
// - Arithmetic at COORD_W+VAL_W+1 bits; no wrap at 0 or VAL_MAX. NONE -> no outputs change.
// - wr_val driven = cur_val, registered same cycle as wr_en (1 cycle after DECODE; latency hit-latch to strobe = 2 cycles).
// - HOLD: wait synced pen high; then RELEASE: pen must stay high REL_CYC consecutive cycles -> IDLE; pen low again -> HOLD.
// - coord_valid outside SETTLE ignored; no dragging: slider acts on initial hit only (except auto-repeat below).
// - Before any grid selection rd_idx=0; slider edits apply to cell 0.
// CONFIGURATION
// - TOUCH_AUTOREPEAT_EN defined: in HOLD with class MINUS/PLUS, after RPT_DLY cycles repeat the step every RPT_PER cycles,
//   each step gated by the same 0/VAL_MAX limits and giving one wr_en; timer clears on leaving HOLD.
// - Undefined: exactly one step per press; repeat timer logic absent.
// TESTING
// - Reset asserted mid-SETTLE -> all outputs 0, FSM IDLE, no wr_en/cell_sel.
// - Pen down, 4 coord pulses, 4th at (45,23) -> cell_sel pulse, col=2,row=2, rd_idx=26; rd_data=0x33 -> later PLUS gives wr_val 0x34.
// - Hit (130,160) on slider -> wr_val=(90*128)/181=63, single wr_en; hit (220,160) -> 127; hit (40,155) -> 0.
// - cur_val=0 press MINUS (25,160) -> no wr_en; cur_val=127 press PLUS (230,160) -> no wr_en.
// - Pen bounce high 5 cycles then low in RELEASE -> back to HOLD, no new event; high 8 cycles -> IDLE, busy 0.
// - TOUCH_AUTOREPEAT_EN, hold PLUS from 100 for RPT_DLY+3*RPT_PER -> wr_en x4, values 101..104; undefined -> 1 strobe.

Source files
------------

// File: rtl/touch_panel_ctrl.sv
// touch_panel_ctrl
//   Touch-panel front end for the synth editor. Turns raw ADC coordinates and
//   the pen IRQ into UI events: picks a cell on a COLS x ROWS character grid,
//   and edits the selected cell with a slider bar plus minus/plus buttons.
//   Every edit action produces one write strobe toward the parameter RAM.
//
//   Optional feature: define TOUCH_AUTOREPEAT_EN to repeat minus/plus steps
//   while the pen is held (after RPT_DLY cycles, then every RPT_PER cycles).
//   Without it every press gives exactly one step and no repeat timer exists.
//
// Ports
//   sys_clk        system clock
//   iRST_n         asynchronous active-low reset
//   x_i, y_i       ADC coordinate, stable while coord_valid_i is high
//   coord_valid_i  one-cycle pulse per new coordinate pair
//   penirq_n_i     pen IRQ, active-low, asynchronous (synchronised here)
//   rd_data_i      value of cell rd_idx_o, combinational from the RAM
//   rd_idx_o       row*COLS+col of the selected cell
//   cell_col_o     selected column
//   cell_row_o     selected row
//   cell_sel_o     one-cycle pulse on a new grid selection
//   wr_val_o       edited value (current value register)
//   wr_en_o        one-cycle write strobe, address = rd_idx_o
//   hit_x_o/hit_y_o latched hit coordinate
//   busy_o         high whenever the FSM is not idle
//   state_o        FSM state for observation
//
// Handshake: coord_valid_i is a qualifier only; there is no back-pressure.
// Samples arriving outside SETTLE are ignored.
module touch_panel_ctrl #(
    parameter int          COORD_W  = 8,
    parameter int          VAL_W    = 8,
    parameter int          VAL_MAX  = 127,
    parameter int          GRID_X0  = 7,
    parameter int          GRID_Y0  = 7,
    parameter int          CELL_W   = 19,
    parameter int          CELL_H   = 8,
    parameter int          COLS     = 12,
    parameter int          ROWS     = 11,
    parameter int          SL_X0    = 40,
    parameter int          SL_X1    = 220,
    parameter int          SL_Y0    = 155,
    parameter int          SL_Y1    = 168,
    parameter int          BTN_W    = 20,
    parameter int          SAMPLE_N = 3,
    parameter int          REL_CYC  = 8,
    parameter logic [23:0] RPT_DLY  = 24'd5_000_000,
    parameter logic [23:0] RPT_PER  = 24'd1_000_000
) (
    input  logic               sys_clk,
    input  logic               iRST_n,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic               coord_valid_i,
    input  logic               penirq_n_i,
    input  logic [VAL_W-1:0]   rd_data_i,
    output logic [7:0]         rd_idx_o,
    output logic [3:0]         cell_col_o,
    output logic [3:0]         cell_row_o,
    output logic               cell_sel_o,
    output logic [VAL_W-1:0]   wr_val_o,
    output logic               wr_en_o,
    output logic [COORD_W-1:0] hit_x_o,
    output logic [COORD_W-1:0] hit_y_o,
    output logic               busy_o,
    output logic [2:0]         state_o
);

    localparam int AW = COORD_W + VAL_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_DECODE, S_ACT, S_LOAD, S_HOLD, S_RELEASE
    } state_t;

    typedef enum logic [2:0] {
        R_NONE, R_GRID, R_SLIDE, R_MINUS, R_PLUS
    } region_t;

    state_t               state_q, state_d;
    region_t              region_q, region_d, region_c;
    logic [1:0]           pen_sync_q;
    logic                 pen_low;
    logic [7:0]           smp_cnt_q, smp_cnt_d;
    logic [7:0]           rel_cnt_q, rel_cnt_d;
    logic [COORD_W-1:0]   hit_x_q, hit_x_d, hit_y_q, hit_y_d;
    logic [3:0]           col_q, col_d, row_q, row_d;
    logic [7:0]           idx_q, idx_d;
    logic [VAL_W-1:0]     cur_val_q, cur_val_d;
    logic                 cell_sel_q, cell_sel_d;
    logic                 wr_en_q, wr_en_d;
    logic                 do_step;

    logic [AW-1:0]        hx, hy, col_c, row_c, slide_raw;
    logic [VAL_W-1:0]     slide_v;
    logic                 in_sly;

`ifdef TOUCH_AUTOREPEAT_EN
    logic [23:0]          rpt_cnt_q, rpt_cnt_d;
    logic                 rpt_wait_q, rpt_wait_d;   // 1 = still in initial delay
`endif

    // Pen IRQ is asynchronous; second flop output is the only one used.
    assign pen_low = ~pen_sync_q[1];

    // Hit classification from the latched coordinate.
    always_comb begin
        hx        = AW'(hit_x_q);
        hy        = AW'(hit_y_q);
        col_c     = (hx - AW'(GRID_X0)) / AW'(CELL_W);
        row_c     = (hy - AW'(GRID_Y0)) / AW'(CELL_H);
        slide_raw = ((hx - AW'(SL_X0)) * AW'(VAL_MAX + 1)) / AW'(SL_X1 - SL_X0 + 1);
        slide_v   = (slide_raw > AW'(VAL_MAX)) ? VAL_W'(VAL_MAX) : slide_raw[VAL_W-1:0];
        in_sly    = (hy >= AW'(SL_Y0)) && (hy <= AW'(SL_Y1));
        region_c  = R_NONE;
        if ((hx >= AW'(GRID_X0)) && (hy >= AW'(GRID_Y0)) &&
            (col_c < AW'(COLS)) && (row_c < AW'(ROWS)))
            region_c = R_GRID;
        else if (in_sly && (hx >= AW'(SL_X0)) && (hx <= AW'(SL_X1)))
            region_c = R_SLIDE;
        else if (in_sly && (hx >= AW'(SL_X0 - BTN_W)) && (hx <= AW'(SL_X0 - 1)))
            region_c = R_MINUS;
        else if (in_sly && (hx >= AW'(SL_X1 + 1)) && (hx <= AW'(SL_X1 + BTN_W)))
            region_c = R_PLUS;
    end

    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        smp_cnt_d  = smp_cnt_q;
        rel_cnt_d  = rel_cnt_q;
        hit_x_d    = hit_x_q;
        hit_y_d    = hit_y_q;
        col_d      = col_q;
        row_d      = row_q;
        idx_d      = idx_q;
        cur_val_d  = cur_val_q;
        cell_sel_d = 1'b0;
        wr_en_d    = 1'b0;
        do_step    = 1'b0;
`ifdef TOUCH_AUTOREPEAT_EN
        rpt_cnt_d  = '0;
        rpt_wait_d = 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                smp_cnt_d = '0;
                if (pen_low) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (!pen_low) begin
                    state_d = S_IDLE;
                end else if (coord_valid_i) begin
                    // First SAMPLE_N samples are discarded while the panel settles.
                    if (smp_cnt_q == 8'(SAMPLE_N)) begin
                        hit_x_d = x_i;
                        hit_y_d = y_i;
                        state_d = S_DECODE;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 8'd1;
                    end
                end
            end
            S_DECODE: begin
                region_d = region_c;
                state_d  = S_ACT;
            end
            S_ACT: begin
                state_d = S_HOLD;
                case (region_q)
                    R_GRID: begin
                        col_d      = 4'(col_c);
                        row_d      = 4'(row_c);
                        idx_d      = 8'(row_c) * 8'(COLS) + 8'(col_c);
                        cell_sel_d = 1'b1;
                        state_d    = S_LOAD;
                    end
                    R_SLIDE: begin
                        cur_val_d = slide_v;
                        wr_en_d   = 1'b1;
                    end
                    R_MINUS, R_PLUS: do_step = 1'b1;
                    default: ;
                endcase
            end
            S_LOAD: begin
                // rd_idx_o has updated, so rd_data_i now belongs to the new cell.
                cur_val_d = rd_data_i;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (!pen_low) begin
                    rel_cnt_d = 8'd1;
                    state_d   = S_RELEASE;
                end
`ifdef TOUCH_AUTOREPEAT_EN
                else if ((region_q == R_MINUS) || (region_q == R_PLUS)) begin
                    if (rpt_cnt_q == (rpt_wait_q ? (RPT_DLY - 24'd1) : (RPT_PER - 24'd1))) begin
                        do_step    = 1'b1;
                        rpt_cnt_d  = '0;
                        rpt_wait_d = 1'b0;
                    end else begin
                        rpt_cnt_d  = rpt_cnt_q + 24'd1;
                        rpt_wait_d = rpt_wait_q;
                    end
                end
`endif
            end
            S_RELEASE: begin
                // rel_cnt_q counts consecutive high cycles including this one minus 1.
                if (pen_low)
                    state_d = S_HOLD;
                else if (rel_cnt_q >= 8'(REL_CYC - 1))
                    state_d = S_IDLE;
                else
                    rel_cnt_d = rel_cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // Saturating step: no strobe when already at the limit.
        if (do_step) begin
            if ((region_q == R_PLUS) && (cur_val_q < VAL_W'(VAL_MAX))) begin
                cur_val_d = cur_val_q + VAL_W'(1);
                wr_en_d   = 1'b1;
            end else if ((region_q == R_MINUS) && (cur_val_q != '0)) begin
                cur_val_d = cur_val_q - VAL_W'(1);
                wr_en_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q    <= S_IDLE;
            region_q   <= R_NONE;
            pen_sync_q <= 2'b11;
            smp_cnt_q  <= '0;
            rel_cnt_q  <= '0;
            hit_x_q    <= '0;
            hit_y_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            idx_q      <= '0;
            cur_val_q  <= '0;
            cell_sel_q <= 1'b0;
            wr_en_q    <= 1'b0;
`ifdef TOUCH_AUTOREPEAT_EN
            rpt_cnt_q  <= '0;
            rpt_wait_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            pen_sync_q <= {pen_sync_q[0], penirq_n_i};
            smp_cnt_q  <= smp_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            hit_x_q    <= hit_x_d;
            hit_y_q    <= hit_y_d;
            col_q      <= col_d;
            row_q      <= row_d;
            idx_q      <= idx_d;
            cur_val_q  <= cur_val_d;
            cell_sel_q <= cell_sel_d;
            wr_en_q    <= wr_en_d;
`ifdef TOUCH_AUTOREPEAT_EN
            rpt_cnt_q  <= rpt_cnt_d;
            rpt_wait_q <= rpt_wait_d;
`endif
        end
    end

    assign rd_idx_o   = idx_q;
    assign cell_col_o = col_q;
    assign cell_row_o = row_q;
    assign cell_sel_o = cell_sel_q;
    assign wr_val_o   = cur_val_q;
    assign wr_en_o    = wr_en_q;
    assign hit_x_o    = hit_x_q;
    assign hit_y_o    = hit_y_q;
    assign busy_o     = (state_q != S_IDLE);
    assign state_o    = state_q;

endmodule

// File: tb/tb_touch_panel_ctrl.sv
// Directed bench for touch_panel_ctrl: touches on grid, slider and buttons
// with hand-computed expected values; write strobes are checked against a
// queue of expected values.
module tb_touch_panel_ctrl;

  logic       sys_clk = 1'b0;
  logic       iRST_n;
  logic [7:0] x, y;
  logic       coord_valid;
  logic       penirq_n;
  logic [7:0] rd_data;
  logic [7:0] rd_idx;
  logic [3:0] cell_col, cell_row;
  logic       cell_sel;
  logic [7:0] wr_val;
  logic       wr_en;
  logic [7:0] hit_x, hit_y;
  logic       busy;
  logic [2:0] state;

  logic [7:0] mem [0:255];
  logic [7:0] exp_q [$];

  int n_chk = 0;
  int n_bad = 0;
  int sel_cnt = 0;
  int wr_cnt = 0;
  logic [3:0] sel_col, sel_row;
  logic [7:0] sel_idx;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_HOLD   = 3'd5;

  assign rd_data = mem[rd_idx];

  touch_panel_ctrl #(
    .RPT_DLY(24'd60),
    .RPT_PER(24'd20)
  ) dut (
    .sys_clk      (sys_clk),
    .iRST_n       (iRST_n),
    .x_i          (x),
    .y_i          (y),
    .coord_valid_i(coord_valid),
    .penirq_n_i   (penirq_n),
    .rd_data_i    (rd_data),
    .rd_idx_o     (rd_idx),
    .cell_col_o   (cell_col),
    .cell_row_o   (cell_row),
    .cell_sel_o   (cell_sel),
    .wr_val_o     (wr_val),
    .wr_en_o      (wr_en),
    .hit_x_o      (hit_x),
    .hit_y_o      (hit_y),
    .busy_o       (busy),
    .state_o      (state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // scoreboard: strobes sampled on the falling edge
  always @(negedge sys_clk) begin
    if (iRST_n && wr_en) begin
      wr_cnt++;
      if (exp_q.size() == 0)
        check("unexpected_wr", {24'd0, wr_val}, 32'hFFFF_FFFF);
      else
        check("wr_val", {24'd0, wr_val}, {24'd0, exp_q.pop_front()});
    end
    if (iRST_n && cell_sel) begin
      sel_cnt++;
      sel_col = cell_col;
      sel_row = cell_row;
      sel_idx = rd_idx;
    end
  end

  // driver tasks
  task automatic send_coord(input int tx, input int ty);
    x = 8'(tx);
    y = 8'(ty);
    coord_valid = 1'b1;
    @(negedge sys_clk);
    coord_valid = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic press(input int tx, input int ty, input int hold);
    penirq_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    for (int i = 0; i < 3; i++) send_coord(0, 0);
    send_coord(tx, ty);
    repeat (hold) @(negedge sys_clk);
  endtask

  task automatic lift(input string tag);
    penirq_n = 1'b1;
    repeat (20) @(negedge sys_clk);
    check(tag, {31'd0, busy}, 32'd0);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  task automatic touch(input string tag, input int tx, input int ty);
    press(tx, ty, 12);
    lift(tag);
  endtask

  int wr_before;
  int sel_before;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[26]  = 8'h33;
    mem[131] = 8'h5A;
    iRST_n = 1'b0;
    penirq_n = 1'b1;
    coord_valid = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(negedge sys_clk);
    iRST_n = 1'b1;
    @(negedge sys_clk);

    // reset state
    check("rst_rd_idx", {24'd0, rd_idx}, 32'd0);
    check("rst_wr_val", {24'd0, wr_val}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {29'd0, state}, {29'd0, ST_IDLE});

    // slider before any selection: cell 0, (90*128)/181 = 63
    exp_q.push_back(8'd63);
    touch("slide130", 130, 160);
    check("slide_rd_idx", {24'd0, rd_idx}, 32'd0);
    check("hit_x", {24'd0, hit_x}, 32'd130);
    check("hit_y", {24'd0, hit_y}, 32'd160);

    // grid (45,23): col 2, row 2, idx 26, loads 0x33
    touch("grid45", 45, 23);
    check("grid_sel_cnt", sel_cnt, 32'd1);
    check("grid_col", {28'd0, sel_col}, 32'd2);
    check("grid_row", {28'd0, sel_row}, 32'd2);
    check("grid_idx", {24'd0, sel_idx}, 32'd26);
    check("grid_load", {24'd0, wr_val}, 32'h33);

    // plus from 0x33
    exp_q.push_back(8'h34);
    touch("plus34", 230, 160);

    // reset in the middle of SETTLE
    penirq_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    send_coord(0, 0);
    send_coord(0, 0);
    check("settle_state", {29'd0, state}, {29'd0, ST_SETTLE});
    iRST_n = 1'b0;
    #1;
    check("arst_wr_val", {24'd0, wr_val}, 32'd0);
    check("arst_col", {28'd0, cell_col}, 32'd0);
    check("arst_row", {28'd0, cell_row}, 32'd0);
    check("arst_idx", {24'd0, rd_idx}, 32'd0);
    check("arst_hit_x", {24'd0, hit_x}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_strobes", {30'd0, wr_en, cell_sel}, 32'd0);
    penirq_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    iRST_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // slider endpoints
    exp_q.push_back(8'd127);
    touch("slide220", 220, 160);
    exp_q.push_back(8'd0);
    touch("slide40", 40, 155);

    // minus at 0: no strobe
    wr_before = wr_cnt;
    touch("minus_at0", 25, 160);
    check("minus_at0_cnt", wr_cnt, wr_before);

    // plus at 127: no strobe; then minus gives 126
    exp_q.push_back(8'd127);
    touch("slide220b", 220, 160);
    wr_before = wr_cnt;
    touch("plus_at_max", 230, 160);
    check("plus_at_max_cnt", wr_cnt, wr_before);
    exp_q.push_back(8'd126);
    touch("minus126", 25, 160);

    // grid edges: x=235 is column 12 (outside), (234,94) is col 11 row 10
    sel_before = sel_cnt;
    wr_before = wr_cnt;
    touch("grid_out", 235, 50);
    touch("none55", 5, 5);
    check("none_sel_cnt", sel_cnt, sel_before);
    check("none_wr_cnt", wr_cnt, wr_before);
    check("none_val", {24'd0, wr_val}, 32'd126);
    touch("grid_edge", 234, 94);
    check("edge_col", {28'd0, sel_col}, 32'd11);
    check("edge_row", {28'd0, sel_row}, 32'd10);
    check("edge_idx", {24'd0, sel_idx}, 32'd131);
    check("edge_load", {24'd0, wr_val}, 32'h5A);

    // exactly SAMPLE_N pulses then release: no event
    sel_before = sel_cnt;
    wr_before = wr_cnt;
    penirq_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    for (int i = 0; i < 3; i++) send_coord(130, 160);
    lift("short_press");
    check("short_sel", sel_cnt, sel_before);
    check("short_wr", wr_cnt, wr_before);

    // slider to 100 ((142*128)/181), then release bounce
    exp_q.push_back(8'd100);
    press(182, 160, 10);
    check("bounce_hold0", {29'd0, state}, {29'd0, ST_HOLD});
    penirq_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    penirq_n = 1'b0;
    repeat (8) @(negedge sys_clk);
    check("bounce_hold1", {29'd0, state}, {29'd0, ST_HOLD});
    check("bounce_busy", {31'd0, busy}, 32'd1);
    lift("bounce_release");
    check("bounce_val", {24'd0, wr_val}, 32'd100);

    // held plus from 100
    exp_q.push_back(8'd101);
`ifdef TOUCH_AUTOREPEAT_EN
    exp_q.push_back(8'd102);
    exp_q.push_back(8'd103);
    exp_q.push_back(8'd104);
`endif
    press(230, 160, 110);
    lift("hold_plus");
`ifdef TOUCH_AUTOREPEAT_EN
    check("hold_val", {24'd0, wr_val}, 32'd104);
`else
    check("hold_val", {24'd0, wr_val}, 32'd101);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
